// File: rtl/river_mem_req_queue.sv
// River memory request queue.
//
// Sits between the River CPU memory port and the system-bus bridge. Cache-line
// requests are buffered in a DEPTH-entry FIFO and issued to the bridge in
// accept order. No more than MAX_OUTSTANDING requests may be issued but not
// yet answered. Bridge responses go straight through to the CPU.
//
// Ports
//   i_clk, i_rst              clock (rising edge), async active-high reset
//   i_req_valid/o_req_ready   CPU request handshake
//   i_req_path/type/addr/size/wdata/wstrb   request fields
//   o_bus_valid/i_bus_ready   bridge request handshake
//   o_bus_path/type/addr/size/wdata/wstrb   head-of-queue request fields
//   i_bus_resp_valid/err      bridge response, one per issued request
//   o_resp_valid/err          response to CPU, zero latency
//   o_outstanding             issued-but-unanswered request count
//   o_idle                    queue empty and nothing in flight
//   o_proto_err               sticky: response arrived with nothing in flight
module river_mem_req_queue #(
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ADDR_BITS       = 48,
    parameter int unsigned LINE_BITS       = 256
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic                   i_req_path,
    input  logic [2:0]             i_req_type,
    input  logic [ADDR_BITS-1:0]   i_req_addr,
    input  logic [2:0]             i_req_size,
    input  logic [LINE_BITS-1:0]   i_req_wdata,
    input  logic [LINE_BITS/8-1:0] i_req_wstrb,
    output logic                   o_bus_valid,
    input  logic                   i_bus_ready,
    output logic                   o_bus_path,
    output logic [2:0]             o_bus_type,
    output logic [ADDR_BITS-1:0]   o_bus_addr,
    output logic [2:0]             o_bus_size,
    output logic [LINE_BITS-1:0]   o_bus_wdata,
    output logic [LINE_BITS/8-1:0] o_bus_wstrb,
    input  logic                   i_bus_resp_valid,
    input  logic                   i_bus_resp_err,
    output logic                   o_resp_valid,
    output logic                   o_resp_err,
    output logic [3:0]             o_outstanding,
    output logic                   o_idle,
    output logic                   o_proto_err
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned STRB_W  = LINE_BITS / 8;
    localparam int unsigned ENTRY_W = 1 + 3 + ADDR_BITS + 3 + LINE_BITS + STRB_W;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [3:0]         outstanding_q, outstanding_d;
    logic               proto_err_q, proto_err_d;

    logic [ENTRY_W-1:0] storage [DEPTH];
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] entry_out;

    logic push;
    logic pop;

    assign o_req_ready = (count_q != CNT_W'(DEPTH));
    assign o_bus_valid = (count_q != '0) && (outstanding_q < 4'(MAX_OUTSTANDING));

    assign push = i_req_valid && o_req_ready;
    assign pop  = o_bus_valid && i_bus_ready;

    assign entry_in  = {i_req_path, i_req_type, i_req_addr, i_req_size, i_req_wdata, i_req_wstrb};
    assign entry_out = storage[rd_ptr_q];
    assign {o_bus_path, o_bus_type, o_bus_addr, o_bus_size, o_bus_wdata, o_bus_wstrb} = entry_out;

    assign o_resp_valid  = i_bus_resp_valid;
    assign o_resp_err    = i_bus_resp_err;
    assign o_outstanding = outstanding_q;
    assign o_idle        = (count_q == '0) && (outstanding_q == '0);
    assign o_proto_err   = proto_err_q;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        proto_err_d   = proto_err_q;

        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        // Issue and response in the same cycle cancel, even at zero in flight.
        if (pop && !i_bus_resp_valid) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (!pop && i_bus_resp_valid) begin
            if (outstanding_q == '0) begin
                proto_err_d = 1'b1;
            end else begin
                outstanding_d = outstanding_q - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            proto_err_q   <= proto_err_d;
        end
    end

    // Payload storage carries no reset; only the control state above does.
    always_ff @(posedge i_clk) begin
        if (push) begin
            storage[wr_ptr_q] <= entry_in;
        end
    end

endmodule

// File: tb/tb_river_mem_req_queue.sv
module tb_river_mem_req_queue;

    localparam int unsigned AB = 48;
    localparam int unsigned LB = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_path = 1'b0;
    logic [2:0]    req_type = '0;
    logic [AB-1:0] req_addr = '0;
    logic [2:0]    req_size = '0;
    logic [LB-1:0] req_wdata = '0;
    logic [LB/8-1:0] req_wstrb = '0;
    logic          bus_ready = 1'b0;
    logic          resp_valid_i = 1'b0;
    logic          resp_err_i = 1'b0;

    // DEPTH=2 / MAX_OUTSTANDING=4 instance
    logic          req_ready, bus_valid, bus_path, resp_valid, resp_err, idle, proto_err;
    logic [2:0]    bus_type, bus_size;
    logic [AB-1:0] bus_addr;
    logic [LB-1:0] bus_wdata;
    logic [LB/8-1:0] bus_wstrb;
    logic [3:0]    outstanding;

    // DEPTH=4 / MAX_OUTSTANDING=15 instance for the wrap test
    logic          req_ready4, bus_valid4, bus_path4, resp_valid4, resp_err4, idle4, proto_err4;
    logic [2:0]    bus_type4, bus_size4;
    logic [AB-1:0] bus_addr4;
    logic [LB-1:0] bus_wdata4;
    logic [LB/8-1:0] bus_wstrb4;
    logic [3:0]    outstanding4;

    int checks = 0;
    int failures = 0;

    river_mem_req_queue #(.DEPTH(2), .MAX_OUTSTANDING(4), .ADDR_BITS(AB), .LINE_BITS(LB)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_path(req_path), .i_req_type(req_type), .i_req_addr(req_addr),
        .i_req_size(req_size), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .o_bus_valid(bus_valid), .i_bus_ready(bus_ready),
        .o_bus_path(bus_path), .o_bus_type(bus_type), .o_bus_addr(bus_addr),
        .o_bus_size(bus_size), .o_bus_wdata(bus_wdata), .o_bus_wstrb(bus_wstrb),
        .i_bus_resp_valid(resp_valid_i), .i_bus_resp_err(resp_err_i),
        .o_resp_valid(resp_valid), .o_resp_err(resp_err),
        .o_outstanding(outstanding), .o_idle(idle), .o_proto_err(proto_err)
    );

    river_mem_req_queue #(.DEPTH(4), .MAX_OUTSTANDING(15), .ADDR_BITS(AB), .LINE_BITS(LB)) u_dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready4),
        .i_req_path(req_path), .i_req_type(req_type), .i_req_addr(req_addr),
        .i_req_size(req_size), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .o_bus_valid(bus_valid4), .i_bus_ready(bus_ready),
        .o_bus_path(bus_path4), .o_bus_type(bus_type4), .o_bus_addr(bus_addr4),
        .o_bus_size(bus_size4), .o_bus_wdata(bus_wdata4), .o_bus_wstrb(bus_wstrb4),
        .i_bus_resp_valid(resp_valid_i), .i_bus_resp_err(resp_err_i),
        .o_resp_valid(resp_valid4), .o_resp_err(resp_err4),
        .o_outstanding(outstanding4), .o_idle(idle4), .o_proto_err(proto_err4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AB-1:0] sb[$];
        int pushed;
        int popped;
        logic push_now;
        logic pop_now;

        // Reset state, observed before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_bus_valid", 64'(bus_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // 1. Async reset in the middle of traffic
        bus_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 48'h40;
        tick();
        tick();
        chk("t1_pre_outstanding", 64'(outstanding), 64'd1);
        chk("t1_pre_bus_valid", 64'(bus_valid), 64'd1);
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t1_bus_valid", 64'(bus_valid), 64'd0);
        chk("t1_req_ready", 64'(req_ready), 64'd1);
        chk("t1_outstanding", 64'(outstanding), 64'd0);
        chk("t1_idle", 64'(idle), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 2. Single read
        bus_ready = 1'b1;
        req_valid = 1'b1;
        req_path  = 1'b1;
        req_type  = 3'b010;
        req_addr  = 48'h8000_0040;
        req_size  = 3'd5;
        chk("t2_no_bypass", 64'(bus_valid), 64'd0);
        tick();
        req_valid = 1'b0;
        chk("t2_bus_valid", 64'(bus_valid), 64'd1);
        chk("t2_bus_addr", 64'(bus_addr), 64'h8000_0040);
        chk("t2_bus_type", 64'(bus_type), 64'd2);
        chk("t2_bus_path", 64'(bus_path), 64'd1);
        chk("t2_bus_size", 64'(bus_size), 64'd5);
        tick();
        chk("t2_issued_valid", 64'(bus_valid), 64'd0);
        chk("t2_outstanding1", 64'(outstanding), 64'd1);
        chk("t2_not_idle", 64'(idle), 64'd0);
        resp_valid_i = 1'b1;
        #1;
        chk("t2_resp_valid", 64'(resp_valid), 64'd1);
        chk("t2_resp_err", 64'(resp_err), 64'd0);
        tick();
        resp_valid_i = 1'b0;
        chk("t2_outstanding0", 64'(outstanding), 64'd0);
        chk("t2_idle", 64'(idle), 64'd1);
        chk("t2_proto_err", 64'(proto_err), 64'd0);

        // 3. Fill with bridge stalled, then drain in order
        bus_ready = 1'b0;
        req_path  = 1'b0;
        req_type  = 3'b000;
        req_valid = 1'b1;
        req_addr  = 48'h100;
        tick();
        req_path  = 1'b1;
        req_addr  = 48'h200;
        chk("t3_ready_b", 64'(req_ready), 64'd1);
        tick();
        req_addr  = 48'h300;
        chk("t3_full", 64'(req_ready), 64'd0);
        tick();
        chk("t3_still_full", 64'(req_ready), 64'd0);
        chk("t3_head_stable", 64'(bus_addr), 64'h100);
        chk("t3_head_path", 64'(bus_path), 64'd0);
        bus_ready = 1'b1;
        tick();
        chk("t3_second", 64'(bus_addr), 64'h200);
        chk("t3_second_path", 64'(bus_path), 64'd1);
        chk("t3_ready_after_pop", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        chk("t3_third", 64'(bus_addr), 64'h300);
        tick();
        chk("t3_outstanding3", 64'(outstanding), 64'd3);
        chk("t3_empty", 64'(bus_valid), 64'd0);

        // 5. Issue and response in the same cycle at outstanding=3
        req_valid = 1'b1;
        req_addr  = 48'h400;
        tick();
        req_valid = 1'b0;
        resp_valid_i = 1'b1;
        chk("t5_issue_valid", 64'(bus_valid), 64'd1);
        tick();
        resp_valid_i = 1'b0;
        chk("t5_outstanding", 64'(outstanding), 64'd3);
        resp_valid_i = 1'b1;
        repeat (3) tick();
        resp_valid_i = 1'b0;
        chk("t5_drained", 64'(outstanding), 64'd0);
        chk("t5_idle", 64'(idle), 64'd1);
        chk("t5_proto_err", 64'(proto_err), 64'd0);

        // 4. Outstanding limit with six requests and no responses
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_addr  = 48'h1000 + 48'(i * 'h40);
            chk("t4_accept", 64'(req_ready), 64'd1);
            tick();
        end
        req_valid = 1'b0;
        chk("t4_outstanding4", 64'(outstanding), 64'd4);
        chk("t4_blocked", 64'(bus_valid), 64'd0);
        chk("t4_queue_full", 64'(req_ready), 64'd0);
        resp_valid_i = 1'b1;
        #1;
        chk("t4_still_blocked", 64'(bus_valid), 64'd0);
        tick();
        resp_valid_i = 1'b0;
        chk("t4_outstanding3", 64'(outstanding), 64'd3);
        chk("t4_fifth_valid", 64'(bus_valid), 64'd1);
        chk("t4_fifth_addr", 64'(bus_addr), 64'h1100);
        tick();
        chk("t4_outstanding_back4", 64'(outstanding), 64'd4);
        chk("t4_blocked_again", 64'(bus_valid), 64'd0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("t4_reset_idle", 64'(idle), 64'd1);

        // 6. Response with nothing in flight
        bus_ready    = 1'b0;
        resp_valid_i = 1'b1;
        resp_err_i   = 1'b1;
        #1;
        chk("t6_resp_valid", 64'(resp_valid), 64'd1);
        chk("t6_resp_err", 64'(resp_err), 64'd1);
        tick();
        resp_valid_i = 1'b0;
        resp_err_i   = 1'b0;
        chk("t6_proto_err", 64'(proto_err), 64'd1);
        chk("t6_outstanding", 64'(outstanding), 64'd0);
        tick();
        tick();
        chk("t6_sticky", 64'(proto_err), 64'd1);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("t6_reset_clears", 64'(proto_err), 64'd0);

        // Wrap test on the DEPTH=4 instance: 10 requests, bridge ready 2 of 3 cycles
        pushed = 0;
        popped = 0;
        for (int cyc = 0; cyc < 40 && popped < 10; cyc++) begin
            bus_ready = (cyc % 3) != 0;
            req_valid = pushed < 10;
            req_addr  = 48'hA000 + 48'(pushed);
            #1;
            push_now = req_valid && req_ready4;
            pop_now  = bus_valid4 && bus_ready;
            if (pop_now) begin
                if (sb.size() == 0) begin
                    chk("wrap_unexpected_issue", 64'(bus_addr4), 64'd0);
                end else begin
                    chk("wrap_order", 64'(bus_addr4), 64'(sb.pop_front()));
                end
                popped++;
            end
            if (push_now) begin
                sb.push_back(req_addr);
                pushed++;
            end
            tick();
        end
        req_valid = 1'b0;
        bus_ready = 1'b0;
        chk("wrap_popped", 64'(popped), 64'd10);
        chk("wrap_outstanding", 64'(outstanding4), 64'd10);
        chk("wrap_empty", 64'(bus_valid4), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
